// File: rtl/axis_frame_mux_if.sv
// AXI4-Stream bundle carrying N parallel streams. Data and sideband fields are
// flattened, so stream i occupies slice i of each field.
// Ports: none. Signals: tdata, tkeep, tvalid, tready, tlast, tid, tdest, tuser.
// Modports: master drives payload and valid and receives tready; slave is the reverse.
interface axis_frame_mux_if #(
  parameter int N          = 1,
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = 8,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 1
) ();
  logic [N*DATA_WIDTH-1:0] tdata;
  logic [N*KEEP_WIDTH-1:0] tkeep;
  logic [N-1:0]            tvalid;
  logic [N-1:0]            tready;
  logic [N-1:0]            tlast;
  logic [N*ID_WIDTH-1:0]   tid;
  logic [N*DEST_WIDTH-1:0] tdest;
  logic [N*USER_WIDTH-1:0] tuser;

  modport master (
    output tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
    output tready
  );
endinterface

// File: rtl/axis_frame_mux.sv
// AXI4-Stream N:1 frame multiplexer. The source port is chosen per frame from
// 'select', and whole frames are forwarded through a two-register skid buffer.
// Frames are never interleaved. An optional source tag is prepended to tdest.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   s_axis    S_COUNT flattened input streams (slave)
//   m_axis    single output stream (master)
//   enable    global gate; when low, every s_axis tready is 0
//   drop      discard the selected frame; sampled at frame start
//   select    source port index; sampled at frame start
module axis_frame_mux #(
  parameter int S_COUNT        = 4,
  parameter int DATA_WIDTH     = 64,
  parameter bit KEEP_ENABLE    = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH     = (DATA_WIDTH + 7) / 8,
  parameter bit ID_ENABLE      = 0,
  parameter int ID_WIDTH       = 8,
  parameter bit DEST_ENABLE    = 0,
  parameter int S_DEST_WIDTH   = 8,
  parameter bit SRC_TAG_ENABLE = 0,
  parameter int M_DEST_WIDTH   = S_DEST_WIDTH + $clog2(S_COUNT),
  parameter bit USER_ENABLE    = 1,
  parameter int USER_WIDTH     = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  axis_frame_mux_if.slave            s_axis,
  axis_frame_mux_if.master           m_axis,
  input  logic                       enable,
  input  logic                       drop,
  input  logic [$clog2(S_COUNT)-1:0] select
);

  localparam int SelWidth = $clog2(S_COUNT);

  if (SRC_TAG_ENABLE && !DEST_ENABLE) begin : g_bad_cfg
    $error("axis_frame_mux: SRC_TAG_ENABLE requires DEST_ENABLE");
  end

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]   data;
    logic [KEEP_WIDTH-1:0]   keep;
    logic                    last;
    logic [ID_WIDTH-1:0]     id;
    logic [M_DEST_WIDTH-1:0] dest;
    logic [USER_WIDTH-1:0]   user;
  } beat_t;

  state_e                state_q, state_d;
  logic [SelWidth-1:0]   select_q, select_d;
  logic                  drop_q, drop_d;
  logic                  ready_int_q, ready_int_d;
  logic                  m_valid_q, m_valid_d;
  logic                  temp_valid_q, temp_valid_d;
  beat_t                 out_q, out_d;
  beat_t                 temp_q, temp_d;

  beat_t                 sel_beat;
  logic                  sel_valid;
  logic [S_DEST_WIDTH-1:0] sel_dest;
  logic                  port_ready;
  logic                  accept;
  logic                  valid_int;
  logic [S_COUNT-1:0]    tready_vec;

  // Input mux on the latched select; an out-of-range index matches no port.
  always_comb begin
    sel_beat  = '0;
    sel_valid = 1'b0;
    sel_dest  = '0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (int'(select_q) == i) begin
        sel_valid     = s_axis.tvalid[i];
        sel_beat.data = s_axis.tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_beat.keep = s_axis.tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        sel_beat.last = s_axis.tlast[i];
        sel_beat.id   = s_axis.tid[i*ID_WIDTH +: ID_WIDTH];
        sel_beat.user = s_axis.tuser[i*USER_WIDTH +: USER_WIDTH];
        sel_dest      = s_axis.tdest[i*S_DEST_WIDTH +: S_DEST_WIDTH];
      end
    end
    if (SRC_TAG_ENABLE) begin
      sel_beat.dest = M_DEST_WIDTH'({select_q, sel_dest});
    end else begin
      sel_beat.dest = M_DEST_WIDTH'(sel_dest);
    end
  end

  // A dropped frame is sunk at full rate, independent of the output path.
  assign port_ready = (state_q == StActive) && enable && (ready_int_q || drop_q);
  assign accept     = port_ready && sel_valid;
  assign valid_int  = accept && !drop_q;

  always_comb begin
    tready_vec = '0;
    for (int i = 0; i < S_COUNT; i++) begin
      tready_vec[i] = port_ready && (int'(select_q) == i);
    end
  end

  assign s_axis.tready = tready_vec;

  always_comb begin
    state_d  = state_q;
    select_d = select_q;
    drop_d   = drop_q;
    case (state_q)
      StIdle: begin
        if (enable) begin
          select_d = select;
          drop_d   = drop || (int'(select) >= S_COUNT);
          state_d  = StActive;
        end
      end
      StActive: begin
        if (accept && sel_beat.last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Skid buffer. ready_int_q is the ready already issued upstream, so a beat
  // may arrive while the output is stalled; that beat is parked in temp.
  always_comb begin
    m_valid_d    = m_valid_q;
    temp_valid_d = temp_valid_q;
    out_d        = out_q;
    temp_d       = temp_q;
    ready_int_d  = m_axis.tready || (!m_valid_q && !temp_valid_q);
    if (ready_int_q) begin
      if (m_axis.tready || !m_valid_q) begin
        m_valid_d = valid_int;
        if (valid_int) begin
          out_d = sel_beat;
        end
      end else begin
        temp_valid_d = valid_int;
        if (valid_int) begin
          temp_d = sel_beat;
        end
      end
    end else if (m_axis.tready) begin
      m_valid_d    = temp_valid_q;
      out_d        = temp_q;
      temp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      select_q     <= '0;
      drop_q       <= 1'b0;
      ready_int_q  <= 1'b0;
      m_valid_q    <= 1'b0;
      temp_valid_q <= 1'b0;
      out_q        <= '0;
      temp_q       <= '0;
    end else begin
      state_q      <= state_d;
      select_q     <= select_d;
      drop_q       <= drop_d;
      ready_int_q  <= ready_int_d;
      m_valid_q    <= m_valid_d;
      temp_valid_q <= temp_valid_d;
      out_q        <= out_d;
      temp_q       <= temp_d;
    end
  end

  assign m_axis.tdata  = out_q.data;
  assign m_axis.tkeep  = KEEP_ENABLE ? out_q.keep : '1;
  assign m_axis.tvalid = m_valid_q;
  assign m_axis.tlast  = out_q.last;
  assign m_axis.tid    = ID_ENABLE ? out_q.id : '0;
  assign m_axis.tdest  = DEST_ENABLE ? out_q.dest : '0;
  assign m_axis.tuser  = USER_ENABLE ? out_q.user : '0;

endmodule

// File: tb/tb_axis_frame_mux.sv
// Directed bench for axis_frame_mux with 4 ports, 16-bit data, all sidebands
// enabled and source tagging on. Inputs change on the falling edge; outputs
// are sampled 1 time unit later, well before the next rising edge.
module tb_axis_frame_mux;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       drop;
  logic [1:0] select;

  int checks;
  int errors;

  axis_frame_mux_if #(
    .N(4), .DATA_WIDTH(16), .KEEP_WIDTH(2), .ID_WIDTH(8), .DEST_WIDTH(8), .USER_WIDTH(1)
  ) s_if ();

  axis_frame_mux_if #(
    .N(1), .DATA_WIDTH(16), .KEEP_WIDTH(2), .ID_WIDTH(8), .DEST_WIDTH(10), .USER_WIDTH(1)
  ) m_if ();

  axis_frame_mux #(
    .S_COUNT(4),
    .DATA_WIDTH(16),
    .KEEP_ENABLE(1'b1),
    .KEEP_WIDTH(2),
    .ID_ENABLE(1'b1),
    .ID_WIDTH(8),
    .DEST_ENABLE(1'b1),
    .S_DEST_WIDTH(8),
    .SRC_TAG_ENABLE(1'b1),
    .M_DEST_WIDTH(10),
    .USER_ENABLE(1'b1),
    .USER_WIDTH(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_axis(s_if),
    .m_axis(m_if),
    .enable(enable),
    .drop(drop),
    .select(select)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_port(input int p, input logic v, input logic [15:0] d, input logic l);
    s_if.tvalid[p]         = v;
    s_if.tdata[p*16 +: 16] = d;
    s_if.tlast[p]          = l;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (m_if.tvalid !== 1'b0) begin
      errors++; $display("FAIL reset_tvalid: got %b want 0", m_if.tvalid);
    end
    checks++;
    if (s_if.tready !== 4'b0000) begin
      errors++; $display("FAIL reset_tready: got %b want 0000", s_if.tready);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (s_if.tready !== 4'b0000 || m_if.tvalid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: tready %b tvalid %b want 0000 0", s_if.tready, m_if.tvalid);
    end
  endtask

  task automatic test_basic();
    @(negedge clk);
    m_if.tready = 1'b1;
    set_port(0, 1'b1, 16'hA000, 1'b0);
    set_port(1, 1'b1, 16'hA100, 1'b0);
    set_port(2, 1'b1, 16'hA200, 1'b0);
    set_port(3, 1'b1, 16'hA300, 1'b0);
    enable = 1'b1; select = 2'd2; drop = 1'b0;
    #1;
    checks++;
    if (s_if.tready !== 4'b0000) begin
      errors++; $display("FAIL basic_idle_tready: got %b want 0000", s_if.tready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (s_if.tready !== 4'b0100 || m_if.tvalid !== 1'b0) begin
      errors++;
      $display("FAIL basic_first_active: tready %b tvalid %b want 0100 0", s_if.tready, m_if.tvalid);
    end
    @(negedge clk);
    set_port(2, 1'b1, 16'hA201, 1'b0);
    #1;
    checks++;
    if (m_if.tvalid !== 1'b1 || m_if.tdata !== 16'hA200 || m_if.tlast !== 1'b0) begin
      errors++;
      $display("FAIL basic_beat0: valid %b data %h last %b want 1 a200 0",
               m_if.tvalid, m_if.tdata, m_if.tlast);
    end
    checks++;
    if (m_if.tdest !== 10'h252 || m_if.tid !== 8'h02 || m_if.tkeep !== 2'b10 ||
        m_if.tuser !== 1'b0) begin
      errors++;
      $display("FAIL basic_sideband: dest %h id %h keep %b user %b want 252 02 10 0",
               m_if.tdest, m_if.tid, m_if.tkeep, m_if.tuser);
    end
    @(negedge clk);
    set_port(2, 1'b1, 16'hA202, 1'b1);
    #1;
    checks++;
    if (m_if.tdata !== 16'hA201 || s_if.tready !== 4'b0100) begin
      errors++;
      $display("FAIL basic_beat1: data %h tready %b want a201 0100", m_if.tdata, s_if.tready);
    end
    @(negedge clk);
    set_port(2, 1'b0, 16'h0000, 1'b0);
    #1;
    checks++;
    if (m_if.tdata !== 16'hA202 || m_if.tlast !== 1'b1 || s_if.tready !== 4'b0000) begin
      errors++;
      $display("FAIL basic_last: data %h last %b tready %b want a202 1 0000",
               m_if.tdata, m_if.tlast, s_if.tready);
    end
    enable = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (m_if.tvalid !== 1'b0) begin
      errors++; $display("FAIL basic_drain: tvalid %b want 0", m_if.tvalid);
    end
  endtask

  task automatic test_select_change();
    @(negedge clk);
    enable = 1'b1; select = 2'd2;
    set_port(2, 1'b1, 16'hA200, 1'b0);
    set_port(1, 1'b1, 16'hA100, 1'b1);
    @(negedge clk);
    select = 2'd1;
    #1;
    checks++;
    if (s_if.tready !== 4'b0100) begin
      errors++; $display("FAIL sel_locked0: tready %b want 0100", s_if.tready);
    end
    @(negedge clk);
    set_port(2, 1'b1, 16'hA201, 1'b0);
    #1;
    checks++;
    if (s_if.tready !== 4'b0100 || m_if.tdata !== 16'hA200) begin
      errors++;
      $display("FAIL sel_locked1: tready %b data %h want 0100 a200", s_if.tready, m_if.tdata);
    end
    @(negedge clk);
    set_port(2, 1'b1, 16'hA202, 1'b1);
    #1;
    checks++;
    if (m_if.tdata !== 16'hA201 || s_if.tready !== 4'b0100) begin
      errors++;
      $display("FAIL sel_locked2: data %h tready %b want a201 0100", m_if.tdata, s_if.tready);
    end
    @(negedge clk);
    set_port(2, 1'b0, 16'h0000, 1'b0);
    #1;
    checks++;
    if (m_if.tdata !== 16'hA202 || m_if.tdest !== 10'h252 || s_if.tready !== 4'b0000) begin
      errors++;
      $display("FAIL sel_frame_end: data %h dest %h tready %b want a202 252 0000",
               m_if.tdata, m_if.tdest, s_if.tready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (s_if.tready !== 4'b0010 || m_if.tvalid !== 1'b0) begin
      errors++;
      $display("FAIL sel_new_port: tready %b tvalid %b want 0010 0", s_if.tready, m_if.tvalid);
    end
    @(negedge clk);
    set_port(1, 1'b0, 16'h0000, 1'b0);
    #1;
    checks++;
    if (m_if.tvalid !== 1'b1 || m_if.tdata !== 16'hA100 || m_if.tlast !== 1'b1 ||
        m_if.tdest !== 10'h151 || s_if.tready !== 4'b0000) begin
      errors++;
      $display("FAIL sel_single_beat: valid %b data %h last %b dest %h tready %b want 1 a100 1 151 0000",
               m_if.tvalid, m_if.tdata, m_if.tlast, m_if.tdest, s_if.tready);
    end
    enable = 1'b0;
  endtask

  task automatic test_enable_pause();
    @(negedge clk);
    enable = 1'b1; select = 2'd1;
    set_port(1, 1'b1, 16'hA100, 1'b0);
    @(negedge clk);
    #1;
    checks++;
    if (s_if.tready !== 4'b0010) begin
      errors++; $display("FAIL pause_start: tready %b want 0010", s_if.tready);
    end
    @(negedge clk);
    set_port(1, 1'b1, 16'hA101, 1'b1);
    enable = 1'b0; select = 2'd3;
    #1;
    checks++;
    if (s_if.tready !== 4'b0000 || m_if.tdata !== 16'hA100) begin
      errors++;
      $display("FAIL pause_gated: tready %b data %h want 0000 a100", s_if.tready, m_if.tdata);
    end
    @(negedge clk);
    enable = 1'b1;
    #1;
    checks++;
    if (s_if.tready !== 4'b0010 || m_if.tvalid !== 1'b0) begin
      errors++;
      $display("FAIL pause_resume: tready %b tvalid %b want 0010 0", s_if.tready, m_if.tvalid);
    end
    @(negedge clk);
    set_port(1, 1'b0, 16'h0000, 1'b0);
    enable = 1'b0;
    #1;
    checks++;
    if (m_if.tdata !== 16'hA101 || m_if.tlast !== 1'b1 || m_if.tdest !== 10'h151) begin
      errors++;
      $display("FAIL pause_tail: data %h last %b dest %h want a101 1 151",
               m_if.tdata, m_if.tlast, m_if.tdest);
    end
  endtask

  task automatic test_stall();
    logic [15:0] exp_d [6];
    logic [15:0] obs_d [6];
    logic        obs_l [6];
    logic        pat [8];
    int idx;
    int got;
    int stray;
    exp_d = '{16'hA000, 16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005};
    pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 6; k++) begin
      obs_d[k] = 16'h0000;
      obs_l[k] = 1'b0;
    end
    idx = 0; got = 0; stray = 0;
    select = 2'd0; drop = 1'b0;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      @(negedge clk);
      m_if.tready = pat[cyc % 8];
      enable = (idx < 6);
      if (idx < 6) set_port(0, 1'b1, 16'(32'hA000 + idx), (idx == 5));
      else set_port(0, 1'b0, 16'h0000, 1'b0);
      #1;
      if ((s_if.tready & 4'b1110) != 4'b0000) stray++;
      if (m_if.tvalid[0] && m_if.tready[0] && got < 6) begin
        obs_d[got] = m_if.tdata;
        obs_l[got] = m_if.tlast[0];
        got++;
      end
      if (s_if.tready[0] && s_if.tvalid[0]) idx++;
    end
    @(negedge clk);
    m_if.tready = 1'b1;
    enable = 1'b0;
    set_port(0, 1'b0, 16'h0000, 1'b0);
    checks++;
    if (got !== 6) begin
      errors++; $display("FAIL stall_count: got %0d beats want 6", got);
    end
    checks++;
    if (stray !== 0) begin
      errors++; $display("FAIL stall_stray_ready: %0d cycles with unselected ready want 0", stray);
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (obs_d[k] !== exp_d[k] || obs_l[k] !== (k == 5)) begin
        errors++;
        $display("FAIL stall_beat%0d: data %h last %b want %h %b",
                 k, obs_d[k], obs_l[k], exp_d[k], (k == 5));
      end
    end
  endtask

  task automatic test_drop();
    @(negedge clk);
    enable = 1'b1; select = 2'd0; drop = 1'b1; m_if.tready = 1'b1;
    set_port(0, 1'b1, 16'hA000, 1'b0);
    #1;
    checks++;
    if (s_if.tready !== 4'b0000) begin
      errors++; $display("FAIL drop_idle: tready %b want 0000", s_if.tready);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drop = 1'b0;
      set_port(0, 1'b1, 16'(32'hA000 + k), (k == 3));
      #1;
      checks++;
      if (s_if.tready !== 4'b0001 || m_if.tvalid !== 1'b0) begin
        errors++;
        $display("FAIL drop_beat%0d: tready %b tvalid %b want 0001 0", k, s_if.tready, m_if.tvalid);
      end
    end
    @(negedge clk);
    set_port(0, 1'b0, 16'h0000, 1'b0);
    #1;
    checks++;
    if (s_if.tready !== 4'b0000 || m_if.tvalid !== 1'b0) begin
      errors++;
      $display("FAIL drop_end: tready %b tvalid %b want 0000 0", s_if.tready, m_if.tvalid);
    end
    enable = 1'b0;
  endtask

  task automatic test_src_tag();
    @(negedge clk);
    enable = 1'b1; select = 2'd3; drop = 1'b0; m_if.tready = 1'b1;
    set_port(3, 1'b1, 16'hA300, 1'b1);
    @(negedge clk);
    #1;
    checks++;
    if (s_if.tready !== 4'b1000) begin
      errors++; $display("FAIL tag_ready: tready %b want 1000", s_if.tready);
    end
    @(negedge clk);
    set_port(3, 1'b0, 16'h0000, 1'b0);
    #1;
    checks++;
    if (m_if.tvalid !== 1'b1 || m_if.tdata !== 16'hA300 || m_if.tdest !== 10'h35A ||
        m_if.tid !== 8'h03 || m_if.tuser !== 1'b1 || m_if.tkeep !== 2'b11) begin
      errors++;
      $display("FAIL tag_beat: valid %b data %h dest %h id %h user %b keep %b want 1 a300 35a 03 1 11",
               m_if.tvalid, m_if.tdata, m_if.tdest, m_if.tid, m_if.tuser, m_if.tkeep);
    end
    checks++;
    if (s_if.tready !== 4'b0000) begin
      errors++; $display("FAIL tag_idle: tready %b want 0000", s_if.tready);
    end
    enable = 1'b0;
  endtask

  task automatic test_reset_midframe();
    @(negedge clk);
    enable = 1'b1; select = 2'd1; m_if.tready = 1'b0;
    set_port(1, 1'b1, 16'hA100, 1'b0);
    @(negedge clk);
    @(negedge clk);
    set_port(1, 1'b1, 16'hA101, 1'b0);
    #1;
    checks++;
    if (m_if.tvalid !== 1'b1 || m_if.tdata !== 16'hA100) begin
      errors++;
      $display("FAIL rstmid_before: valid %b data %h want 1 a100", m_if.tvalid, m_if.tdata);
    end
    @(negedge clk);
    set_port(1, 1'b1, 16'hA102, 1'b1);
    #2;
    rst = 1'b1;
    enable = 1'b0;
    #1;
    checks++;
    if (m_if.tvalid !== 1'b0 || s_if.tready !== 4'b0000) begin
      errors++;
      $display("FAIL rstmid_async: tvalid %b tready %b want 0 0000", m_if.tvalid, s_if.tready);
    end
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b1; select = 2'd1; m_if.tready = 1'b1;
    set_port(1, 1'b1, 16'hA100, 1'b0);
    #1;
    checks++;
    if (s_if.tready !== 4'b0000 || m_if.tvalid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_idle: tready %b tvalid %b want 0000 0", s_if.tready, m_if.tvalid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (s_if.tready !== 4'b0010) begin
      errors++; $display("FAIL rstmid_restart: tready %b want 0010", s_if.tready);
    end
    @(negedge clk);
    set_port(1, 1'b1, 16'hA101, 1'b1);
    #1;
    checks++;
    if (m_if.tvalid !== 1'b1 || m_if.tdata !== 16'hA100 || m_if.tlast !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_beat0: valid %b data %h last %b want 1 a100 0",
               m_if.tvalid, m_if.tdata, m_if.tlast);
    end
    @(negedge clk);
    set_port(1, 1'b0, 16'h0000, 1'b0);
    enable = 1'b0;
    #1;
    checks++;
    if (m_if.tvalid !== 1'b1 || m_if.tdata !== 16'hA101 || m_if.tlast !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_beat1: valid %b data %h last %b want 1 a101 1",
               m_if.tvalid, m_if.tdata, m_if.tlast);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    enable = 1'b0;
    drop = 1'b0;
    select = 2'd0;
    s_if.tvalid = '0;
    s_if.tdata  = '0;
    s_if.tlast  = '0;
    s_if.tkeep  = {2'b11, 2'b10, 2'b01, 2'b11};
    s_if.tid    = {8'h03, 8'h02, 8'h01, 8'h00};
    s_if.tdest  = {8'h5A, 8'h52, 8'h51, 8'h50};
    s_if.tuser  = 4'b1010;
    m_if.tready = 1'b1;

    test_reset();
    test_basic();
    test_select_change();
    test_enable_pause();
    test_stall();
    test_drop();
    test_src_tag();
    test_reset_midframe();

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
